// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - request FIFO and one-at-a-time issue sequencer for the multi-cycle ALU
//
// Buffers tagged ALU requests in a DEPTH-entry circular FIFO, issues them in order to the ALU,
// waits for each result and presents it with its tag on a ready/valid result port.
//
// Optional feature macro: ALU_ISSUE_TIMEOUT_EN (WAIT-state watchdog, limit TIMEOUT cycles).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_a, req_b, req_op, req_tag request payload
//   alu_a, alu_b, alu_op     operands/opcode to the ALU, taken from the FIFO head
//   alu_valid_i              one-cycle issue strobe to the ALU
//   alu_z, alu_valid_o       ALU result and its level-held valid
//   res_valid/res_ready      result handshake; res_z, res_tag, res_err result payload
//   count                    FIFO occupancy
//   busy                     FSM not idle or FIFO not empty
module alu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [63:0]                req_a,
  input  logic [63:0]                req_b,
  input  logic [3:0]                 req_op,
  input  logic [TAG_W-1:0]           req_tag,
  output logic [63:0]                alu_a,
  output logic [63:0]                alu_b,
  output logic [3:0]                 alu_op,
  output logic                       alu_valid_i,
  input  logic [63:0]                alu_z,
  input  logic                       alu_valid_o,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [63:0]                res_z,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t            state, state_n;
  logic [63:0]       a_mem   [DEPTH];
  logic [63:0]       b_mem   [DEPTH];
  logic [3:0]        op_mem  [DEPTH];
  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic [TAG_W-1:0]  inflight_tag;
  logic [63:0]       res_z_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic              push, issue, take;

  assign req_ready = !rst && (count_q != CW'(DEPTH));
  assign push      = req_valid && req_ready;

  assign alu_a  = a_mem[rd_ptr];
  assign alu_b  = b_mem[rd_ptr];
  assign alu_op = op_mem[rd_ptr];
  // Gated by rst so a reset landing in an issuing cycle never starts the ALU.
  assign alu_valid_i = issue && !rst;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          expire;
  logic          res_err_q;
`endif

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    take    = 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
    expire  = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (count_q != '0) begin
          issue   = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result in the same cycle as the limit wins over the timeout.
        if (alu_valid_o) begin
          take    = 1'b1;
          state_n = S_HOLD;
        end
`ifdef ALU_ISSUE_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT)) begin
          expire  = 1'b1;
          state_n = S_HOLD;
        end
`endif
      end
      S_HOLD: begin
        // Back-to-back: the handshake cycle also issues the next head entry.
        if (res_ready) begin
          if (count_q != '0) begin
            issue   = 1'b1;
            state_n = S_WAIT;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      inflight_tag <= '0;
      res_z_q      <= '0;
      res_tag_q    <= '0;
    end else begin
      state <= state_n;
      if (push) begin
        a_mem[wr_ptr]   <= req_a;
        b_mem[wr_ptr]   <= req_b;
        op_mem[wr_ptr]  <= req_op;
        tag_mem[wr_ptr] <= req_tag;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (issue) begin
        rd_ptr       <= rd_ptr + PW'(1);
        inflight_tag <= tag_mem[rd_ptr];
      end
      case ({push, issue})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (take) begin
        res_z_q   <= alu_z;
        res_tag_q <= inflight_tag;
      end
`ifdef ALU_ISSUE_TIMEOUT_EN
      if (expire) begin
        res_z_q   <= '0;
        res_tag_q <= inflight_tag;
      end
`endif
    end
  end

`ifdef ALU_ISSUE_TIMEOUT_EN
  // Cleared on every issue (the only way into WAIT), so it counts cycles spent in WAIT.
  always_ff @(posedge clk) begin
    if (rst || issue) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_err_q <= 1'b0;
    end else if (take) begin
      res_err_q <= 1'b0;
    end else if (expire) begin
      res_err_q <= 1'b1;
    end
  end

  assign res_err = res_err_q;
`else
  // TIMEOUT only matters with the watchdog; this always evaluates to 0.
  assign res_err = (TIMEOUT < 0);
`endif

  assign res_valid = (state == S_HOLD);
  assign res_z     = res_z_q;
  assign res_tag   = res_tag_q;
  assign count     = count_q;
  assign busy      = (state != S_IDLE) || (count_q != '0);

endmodule
